// File: rtl/rr_stream_mux.sv
// rr_stream_mux: round-robin arbiter/multiplexer over 2**SELECT_WIDTH
// valid/ready input streams, with one registered output stage.
// Optional build macro RR_STREAM_MUX_LOCK_EN adds lock_in for multi-beat
// atomic sequences that hold the grant on one channel.
module rr_stream_mux #(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned SELECT_WIDTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [WIDTH-1:0]             data_in [2**SELECT_WIDTH],
  input  logic [2**SELECT_WIDTH-1:0]   valid_in,
`ifdef RR_STREAM_MUX_LOCK_EN
  input  logic [2**SELECT_WIDTH-1:0]   lock_in,
`endif
  output logic [2**SELECT_WIDTH-1:0]   ready_in,
  output logic [WIDTH-1:0]             data_out,
  output logic [SELECT_WIDTH-1:0]      index_out,
  output logic                         valid_out,
  input  logic                         ready_out
);

  localparam int unsigned CHANNELS = 2**SELECT_WIDTH;

  logic [WIDTH-1:0]        r_data;
  logic [SELECT_WIDTH-1:0] r_index;
  logic                    r_valid;
  logic [SELECT_WIDTH-1:0] r_last_grant;

  logic                    w_load;
  logic                    w_any;
  logic [SELECT_WIDTH-1:0] w_grant;
  logic                    w_take;

`ifdef RR_STREAM_MUX_LOCK_EN
  logic                    r_locked;
`endif

  // Output stage can accept a new beat when empty or being drained.
  assign w_load = !r_valid || ready_out;

  // Search for the first valid channel after the last grant, wrapping fully.
  always_comb begin
    logic [SELECT_WIDTH-1:0] w_idx;
    w_grant = r_last_grant;
    w_any   = 1'b0;
    w_idx   = '0;
    for (int unsigned i = 1; i <= CHANNELS; i++) begin
      w_idx = r_last_grant + SELECT_WIDTH'(i);
      if (!w_any && valid_in[w_idx]) begin
        w_grant = w_idx;
        w_any   = 1'b1;
      end
    end
`ifdef RR_STREAM_MUX_LOCK_EN
    // A locked arbiter only serves the channel that took the lock.
    if (r_locked) begin
      w_grant = r_last_grant;
      w_any   = valid_in[r_last_grant];
    end
`endif
  end

  // Grant is accepted only when the output stage can load and not in reset.
  assign w_take   = w_load && w_any && !reset;
  assign ready_in = w_take ? (CHANNELS'(1) << w_grant) : '0;

  // Output register and round-robin pointer update.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid      <= 1'b0;
      r_data       <= '0;
      r_index      <= '0;
      r_last_grant <= SELECT_WIDTH'(CHANNELS - 1);
    end else if (w_load) begin
      if (w_any) begin
        r_valid      <= 1'b1;
        r_data       <= data_in[w_grant];
        r_index      <= w_grant;
        r_last_grant <= w_grant;
      end else begin
        r_valid      <= 1'b0;
      end
    end
  end

`ifdef RR_STREAM_MUX_LOCK_EN
  // Lock follows lock_in of the granted channel on every transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_locked <= 1'b0;
    end else if (w_take) begin
      r_locked <= lock_in[w_grant];
    end
  end
`endif

  assign data_out  = r_data;
  assign index_out = r_index;
  assign valid_out = r_valid;

endmodule

// File: tb/tb_rr_stream_mux.sv
// Directed testbench for rr_stream_mux (4 channels, 16-bit data).
module tb_rr_stream_mux;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned SW    = 2;
  localparam int unsigned CH    = 4;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] data_in [CH];
  logic [CH-1:0]    valid_in;
  logic [CH-1:0]    ready_in;
  logic [WIDTH-1:0] data_out;
  logic [SW-1:0]    index_out;
  logic             valid_out;
  logic             ready_out;
`ifdef RR_STREAM_MUX_LOCK_EN
  logic [CH-1:0]    lock_in;
`endif

  int n_cmp;
  int n_bad;

  rr_stream_mux #(.WIDTH(WIDTH), .SELECT_WIDTH(SW)) dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .valid_in  (valid_in),
`ifdef RR_STREAM_MUX_LOCK_EN
    .lock_in   (lock_in),
`endif
    .ready_in  (ready_in),
    .data_out  (data_out),
    .index_out (index_out),
    .valid_out (valid_out),
    .ready_out (ready_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [WIDTH-1:0] pat [CH];
    n_cmp = 0;
    n_bad = 0;
    pat[0] = 16'h000A; pat[1] = 16'h000B; pat[2] = 16'h000C; pat[3] = 16'h000D;
    for (int i = 0; i < int'(CH); i++) data_in[i] = '0;
    valid_in  = '0;
    ready_out = 1'b1;
    reset     = 1'b1;
`ifdef RR_STREAM_MUX_LOCK_EN
    lock_in   = '0;
`endif
    step();
    step();
    reset = 1'b0;
    step();

    // Idle after reset
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_data",  32'(data_out),  32'd0);
    chk("rst_index", 32'(index_out), 32'd0);
    chk("rst_ready", 32'(ready_in),  32'h0);

    // All channels valid: rotation 0,1,2,3,0,1,2,3
    for (int i = 0; i < int'(CH); i++) data_in[i] = pat[i];
    valid_in = 4'b1111;
    #1;
    chk("rot_ready0", 32'(ready_in), 32'h1);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("rot_valid", 32'(valid_out), 32'd1);
      chk("rot_index", 32'(index_out), 32'(i % 4));
      chk("rot_data",  32'(data_out),  32'(pat[i % 4]));
    end

    // Only ch2 valid: re-granted every cycle
    valid_in   = 4'b0100;
    data_in[2] = 16'h1234;
    #1;
    chk("solo_ready0", 32'(ready_in), 32'h4);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("solo_index", 32'(index_out), 32'd2);
      chk("solo_data",  32'(data_out),  32'h1234);
      chk("solo_ready", 32'(ready_in),  32'h4);
    end

    // Backpressure with index_out=1
    data_in[2] = pat[2];
    valid_in   = 4'b0010;
    step();
    chk("bp_setup", 32'(index_out), 32'd1);
    ready_out = 1'b0;
    valid_in  = 4'b1111;
    #1;
    chk("bp_ready0", 32'(ready_in), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_valid", 32'(valid_out), 32'd1);
      chk("bp_index", 32'(index_out), 32'd1);
      chk("bp_data",  32'(data_out),  32'h000B);
      chk("bp_ready", 32'(ready_in),  32'h0);
    end
    ready_out = 1'b1;
    #1;
    chk("bp_rel_ready", 32'(ready_in), 32'h4);
    step();
    chk("bp_rel_index", 32'(index_out), 32'd2);
    chk("bp_rel_data",  32'(data_out),  32'h000C);

    // Wrap: grant ch3, then 4'b1001 gives ch0 then ch3
    valid_in = 4'b1000;
    step();
    chk("wrap_g3", 32'(index_out), 32'd3);
    valid_in = 4'b1001;
    step();
    chk("wrap_g0", 32'(index_out), 32'd0);
    chk("wrap_d0", 32'(data_out),  32'h000A);
    step();
    chk("wrap_g3b", 32'(index_out), 32'd3);

    // Reset mid-stream
    valid_in = 4'b1111;
    reset    = 1'b1;
    #1;
    chk("mrst_ready", 32'(ready_in), 32'h0);
    step();
    chk("mrst_valid", 32'(valid_out), 32'd0);
    chk("mrst_data",  32'(data_out),  32'd0);
    chk("mrst_index", 32'(index_out), 32'd0);
    reset = 1'b0;
    step();
    chk("mrst_g0",  32'(index_out), 32'd0);
    chk("mrst_v0",  32'(valid_out), 32'd1);
    chk("mrst_d0",  32'(data_out),  32'h000A);
    step();
    chk("mrst_g1", 32'(index_out), 32'd1);

    // No input pending: valid drops, data/index hold
    valid_in = 4'b0000;
    #1;
    chk("idle_ready", 32'(ready_in), 32'h0);
    step();
    chk("idle_valid", 32'(valid_out), 32'd0);
    chk("idle_index", 32'(index_out), 32'd1);
    chk("idle_data",  32'(data_out),  32'h000B);

`ifdef RR_STREAM_MUX_LOCK_EN
    // Lock on ch1 for three locked beats plus the releasing beat
    valid_in = 4'b0001;
    step();
    chk("lk_setup", 32'(index_out), 32'd0);
    valid_in = 4'b1111;
    lock_in  = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("lk_beat", 32'(index_out), 32'd1);
    end
    lock_in = 4'b0000;
    #1;
    chk("lk_ready", 32'(ready_in), 32'h2);
    step();
    chk("lk_last", 32'(index_out), 32'd1);
    step();
    chk("lk_after", 32'(index_out), 32'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
